voice_ram_mp: RTL and testbench
===============================

Name: voice_ram_mp

Overview:
- Parametrised multi-read-port, single-write-port synchronous RAM for per-voice synthesizer state: phase accumulators, envelope levels and oscillator parameters.
- Successor to the fixed 4-read/256x32 voice store. Adds:
  - configurable width, depth and read-port count;
  - per-port read enables;
  - byte-enable writes;
  - optional write-to-read bypass;
  - a hardware clear sequencer that replaces simulation-only memory initialisation.
- Sits between the control/register interface (writer) and the voice engines (readers).

Parameters:
DATA_W, 32, data word width; must be a multiple of 8
ADDR_W, 8, address width; DEPTH = 2**ADDR_W
NUM_RD, 4, number of independent read ports (1..8)
BYPASS, 1, 1 = same-cycle write forwarded to matching read; 0 = read-first (old data)
CLEAR_ON_RST, 1, 1 = clear sequence starts automatically on reset release

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
raddr  in  NUM_RD*ADDR_W  packed read addresses; port k = bits [k*ADDR_W +: ADDR_W]
rd_en  in  NUM_RD  per-port read enable
dout  out  NUM_RD*DATA_W  packed registered read data; port k = bits [k*DATA_W +: DATA_W]
waddr  in  ADDR_W  write address
we  in  1  write strobe
wbe  in  DATA_W/8  byte enables; bit b covers din[8b+7:8b]
din  in  DATA_W  write data
clr_req  in  1  pulse: request full-memory clear
busy  out  1  high while clear sequence runs

Behaviour:
- Reset: sampled on clk edge while rst_n=0.
  - dout <= 0 on all ports.
  - clr_addr <= 0.
  - State <= CLEAR if CLEAR_ON_RST, else IDLE.
  - busy reset value = CLEAR_ON_RST.
  - Memory contents are untouched by reset itself.
- Reset mid-clear: the sequence restarts from address 0 (CLEAR_ON_RST=1) or is abandoned (CLEAR_ON_RST=0). Partially cleared contents remain.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when clr_req=1.
  - CLEAR -> IDLE on the cycle clr_addr = DEPTH-1 is written.
  - clr_req in CLEAR is ignored.
- CLEAR:
  - Each cycle writes 0 to M[clr_addr] and increments clr_addr.
  - Exactly DEPTH cycles; busy=1 for every one of them. busy falls on the edge after the last write.
  - clr_addr wraps to 0 on exit.
  - User we is ignored (no write occurs).
  - Enabled reads load dout_k <= 0.
- Read latency: 1 cycle.
  - If rd_en[k]=1 at edge N, dout_k holds M[raddr_k] from edge N onward.
  - If rd_en[k]=0, dout_k holds its previous value.
  - Ports are fully independent; any number may share an address.
- Write (IDLE, we=1): for each byte b with wbe[b]=1, M[waddr] byte b <= din byte b. Other bytes are unchanged. we=1 with wbe=0 is a no-op.
- Read-during-write, same address, same edge:
  - BYPASS=1: dout_k = byte-merge(old word, din, wbe), i.e. the post-write value.
  - BYPASS=0: dout_k = old word.
- Different addresses: no interaction.
- Arithmetic: clr_addr is ADDR_W bits; terminal compare is against all-ones. No other arithmetic.
- Elaboration error if DATA_W % 8 != 0 or NUM_RD outside 1..8.

Decomposition:
- Shared package voice_mem_pkg holds:
  - state encoding localparams ST_IDLE=1'b0, ST_CLEAR=1'b1;
  - the byte-merge function used by both the write path and the bypass path.
- One sub-module, voice_ram_rd_port: a registered read stage with enable, clear-force-zero and bypass mux. It is instantiated NUM_RD times by generate.
- Storage array, write path and clear FSM stay in the top.

Test Plan:
- Reset release with CLEAR_ON_RST=1 (defaults): busy=1 for exactly 256 cycles then 0; afterwards all 4 ports reading addrs 0,85,170,255 return 0x00000000.
- Write addr 0x12 din=0xDEADBEEF wbe=4'b1111, then wbe=4'b0011 din=0x00001234: next read of 0x12 returns 0xDEAD1234 with 1-cycle latency.
- Same-edge write 0xCAFEF00D to 0x40 (wbe=4'hF, old 0x11111111) and port 2 reading 0x40: BYPASS=1 -> dout2=0xCAFEF00D; BYPASS=0 -> 0x11111111, then 0xCAFEF00D on the next read.
- rd_en=4'b0101 with all raddr=0x12: ports 0 and 2 update to 0xDEAD1234; ports 1 and 3 hold prior values.
- clr_req pulse in IDLE, with we=1 to 0x05 during CLEAR: write is dropped; after 256 busy cycles M[0x05]=0; second clr_req mid-clear leaves duration at 256.
- rst_n low for 1 cycle at clear cycle 100: dout=0 on the reset edge; the clear restarts and busy stays high for 256 further cycles.

Source files
------------

// File: rtl/voice_mem_pkg.sv
// voice_mem_pkg: clear-FSM state encoding and the byte-merge used by write and bypass paths
package voice_mem_pkg;
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;
  function automatic logic [7:0] byte_merge(input logic [7:0] old_b, input logic [7:0] new_b, input logic en);
    return en ? new_b : old_b;
  endfunction
endpackage

// File: rtl/voice_ram_rd_port.sv
// voice_ram_rd_port: registered read stage; clk/rst_n, i_en read enable, i_clr force-zero, i_hit same-edge write match, i_mem_word/i_byp_word sources, o_dout registered data
module voice_ram_rd_port #(
  parameter int DATA_W = 32,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic              i_hit,
  input  logic [DATA_W-1:0] i_mem_word,
  input  logic [DATA_W-1:0] i_byp_word,
  output logic [DATA_W-1:0] o_dout
);
  logic [DATA_W-1:0] r_dout;
  logic [DATA_W-1:0] w_src;
  always_comb w_src = i_clr ? '0 : ((BYPASS != 0) && i_hit) ? i_byp_word : i_mem_word;
  always_ff @(posedge clk)
    if (!rst_n) r_dout <= '0;
    else if (i_en) r_dout <= w_src;
  assign o_dout = r_dout;
endmodule

// File: rtl/voice_ram_mp.sv
// voice_ram_mp: multi-read/single-write voice RAM; raddr/rd_en/dout per read port, waddr/we/wbe/din write port, clr_req/busy hardware clear
module voice_ram_mp
  import voice_mem_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 8,
  parameter int NUM_RD       = 4,
  parameter int BYPASS       = 1,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  input  logic [NUM_RD-1:0]        rd_en,
  output logic [NUM_RD*DATA_W-1:0] dout,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic                     we,
  input  logic [DATA_W/8-1:0]      wbe,
  input  logic [DATA_W-1:0]        din,
  input  logic                     clr_req,
  output logic                     busy
);
  localparam int DEPTH = 1 << ADDR_W;
  if (DATA_W % 8 != 0 || NUM_RD < 1 || NUM_RD > 8) begin : g_bad_cfg
    $error("voice_ram_mp: DATA_W must be a multiple of 8 and NUM_RD in 1..8");
  end
  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] w_old, w_wr_word;
  logic              w_clear, w_wr_en;
  assign w_clear = r_state == ST_CLEAR;
  assign w_wr_en = !w_clear && we && |wbe;
  assign w_old   = r_mem[waddr];
  assign busy    = w_clear;
  // the merged word is both what gets stored and what a bypassing reader sees
  for (genvar b = 0; b < DATA_W/8; b++) begin : g_merge
    assign w_wr_word[8*b +: 8] = byte_merge(w_old[8*b +: 8], din[8*b +: 8], wbe[b]);
  end
  always_comb w_state_nxt = w_clear ? ((&r_clr_addr) ? ST_IDLE : ST_CLEAR)
                                    : (clr_req ? ST_CLEAR : ST_IDLE);
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_state    <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
      r_clr_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clear) r_clr_addr <= r_clr_addr + 1'b1;
    end
  // storage is never touched on a reset edge
  always_ff @(posedge clk)
    if (rst_n) begin
      if (w_clear) r_mem[r_clr_addr] <= '0;
      else if (w_wr_en) r_mem[waddr] <= w_wr_word;
    end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    assign w_ra = raddr[k*ADDR_W +: ADDR_W];
    voice_ram_rd_port #(.DATA_W(DATA_W), .BYPASS(BYPASS)) u_port (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_en      (rd_en[k]),
      .i_clr     (w_clear),
      .i_hit     (w_wr_en && (w_ra == waddr)),
      .i_mem_word(r_mem[w_ra]),
      .i_byp_word(w_wr_word),
      .o_dout    (dout[k*DATA_W +: DATA_W])
    );
  end
endmodule

// File: tb/tb_voice_ram_mp.sv
// tb_voice_ram_mp: directed checks of voice_ram_mp with bypass and read-first instances
module tb_voice_ram_mp;
  logic         clk = 0;
  logic         rst_n;
  logic [31:0]  raddr;
  logic [3:0]   rd_en;
  logic [127:0] dout, dout_rf;
  logic [7:0]   waddr;
  logic         we;
  logic [3:0]   wbe;
  logic [31:0]  din;
  logic         clr_req;
  logic         busy, busy_rf;
  int           n_chk = 0;
  int           n_fail = 0;
  int           cnt;
  always #5 clk = ~clk;
  voice_ram_mp dut (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rd_en(rd_en), .dout(dout),
    .waddr(waddr), .we(we), .wbe(wbe), .din(din), .clr_req(clr_req), .busy(busy)
  );
  voice_ram_mp #(.BYPASS(0)) dut_rf (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rd_en(rd_en), .dout(dout_rf),
    .waddr(waddr), .we(we), .wbe(wbe), .din(din), .clr_req(clr_req), .busy(busy_rf)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] port(input logic [127:0] d, input int k);
    return d[k*32 +: 32];
  endfunction
  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    waddr = a; din = d; wbe = be; we = 1;
    tick();
    we = 0;
  endtask
  task automatic busy_count(input int pulse_at, output int n);
    n = 0;
    while (busy && n < 1000) begin
      clr_req = (n == pulse_at);
      tick();
      n++;
    end
    clr_req = 0;
  endtask
  initial begin
    rst_n = 0; raddr = '0; rd_en = '0; waddr = '0; we = 0; wbe = '0; din = '0; clr_req = 0;
    tick(); tick();
    chk("rst_dout0", port(dout, 0), 32'h0);
    chk("rst_dout3", port(dout, 3), 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h1);
    rst_n = 1;
    busy_count(-1, cnt);
    chk("init_clear_len", cnt, 256);
    chk("init_busy_rf", {31'b0, busy_rf}, 32'h0);
    raddr = {8'd255, 8'd170, 8'd85, 8'd0}; rd_en = 4'hF;
    tick();
    rd_en = 0;
    for (int k = 0; k < 4; k++) chk($sformatf("clr_rd%0d", k), port(dout, k), 32'h0);
    wr(8'h12, 32'hDEADBEEF, 4'hF);
    wr(8'h12, 32'h00001234, 4'h3);
    wr(8'h12, 32'hFFFFFFFF, 4'h0);
    raddr = {4{8'h12}}; rd_en = 4'b0001;
    tick();
    chk("be_merge_p0", port(dout, 0), 32'hDEAD1234);
    chk("be_hold_p1", port(dout, 1), 32'h0);
    rd_en = 4'b0101;
    tick();
    rd_en = 0;
    chk("en_p0", port(dout, 0), 32'hDEAD1234);
    chk("en_p1_hold", port(dout, 1), 32'h0);
    chk("en_p2", port(dout, 2), 32'hDEAD1234);
    chk("en_p3_hold", port(dout, 3), 32'h0);
    wr(8'h40, 32'h11111111, 4'hF);
    raddr = {8'h0, 8'h40, 8'h0, 8'h0}; rd_en = 4'b0100;
    wr(8'h40, 32'hCAFEF00D, 4'hF);
    chk("byp_new", port(dout, 2), 32'hCAFEF00D);
    chk("rf_old", port(dout_rf, 2), 32'h11111111);
    tick();
    chk("rf_next", port(dout_rf, 2), 32'hCAFEF00D);
    wr(8'h40, 32'hAB000000, 4'h8);
    chk("byp_part", port(dout, 2), 32'hABFEF00D);
    chk("rf_part_old", port(dout_rf, 2), 32'hCAFEF00D);
    rd_en = 0;
    wr(8'h05, 32'h55AA55AA, 4'hF);
    clr_req = 1;
    tick();
    clr_req = 0;
    chk("clr_busy", {31'b0, busy}, 32'h1);
    waddr = 8'h05; din = 32'hFFFFFFFF; wbe = 4'hF; we = 1;
    cnt = 0;
    while (busy && cnt < 1000) begin
      clr_req = (cnt == 50);
      rd_en = (cnt == 10) ? 4'hF : 4'h0;
      raddr = {4{8'h12}};
      tick();
      if (cnt == 10) chk("clr_force0", port(dout, 0), 32'h0);
      cnt++;
    end
    clr_req = 0; we = 0; rd_en = 0;
    chk("clr_len_req2", cnt, 256);
    wr(8'h20, 32'h13572468, 4'hF);
    raddr = {4{8'h20}}; rd_en = 4'hF;
    tick();
    chk("post_clr_wr", port(dout, 1), 32'h13572468);
    raddr = {4{8'h05}}; rd_en = 4'b0001;
    tick();
    chk("clr_drop_we", port(dout, 0), 32'h0);
    chk("clr_drop_rf", port(dout_rf, 0), 32'h0);
    raddr = {4{8'h40}}; rd_en = 4'b0100;
    tick();
    rd_en = 0;
    chk("clr_0x40", port(dout, 2), 32'h0);
    raddr = {4{8'h20}}; rd_en = 4'hF;
    tick();
    rd_en = 0;
    clr_req = 1;
    tick();
    clr_req = 0;
    repeat (100) tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    for (int k = 0; k < 4; k++) chk($sformatf("midrst_dout%0d", k), port(dout, k), 32'h0);
    chk("midrst_busy", {31'b0, busy}, 32'h1);
    busy_count(-1, cnt);
    chk("midrst_len", cnt, 256);
    chk("midrst_busy_rf", {31'b0, busy_rf}, 32'h0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
